// File: rtl/fifo_n_if.sv
// Producer/consumer bus for fifo_n. The FIFO takes the slave modport; the
// stage driving requests and consuming data takes the master modport.
//
// Handshake: write_en and read_en are requests. A write is accepted when
// write_en && write_rdy, and a read when read_en && read_rdy, both at the
// rising clock edge. write_rdy/read_rdy depend only on registered state, so a
// requester may hold en high while rdy is low without creating a combinational
// loop. read_data is valid whenever read_rdy is high.
interface fifo_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             write_rdy;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             read_rdy;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             almost_empty;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_en, write_data, read_en, err_clr,
    input  write_rdy, read_data, read_rdy, count,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  write_en, write_data, read_en, err_clr,
    output write_rdy, read_data, read_rdy, count,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_n.sv
// Parametrised first-word-fall-through synchronous FIFO with occupancy count
// and almost-full/almost-empty flags. Define FIFO_N_ERR_FLAGS_EN to build the
// sticky overflow/underflow flags; otherwise they are tied low.
module fifo_n #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic      CLK,
  input  logic      RST_N,
  fifo_n_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             write_rdy, read_rdy;
  logic             wr_acc, rd_acc;

  // Ready flags come from registered count only, never from the requests.
  assign write_rdy = (count_q != FULL_CNT);
  assign read_rdy  = (count_q != '0);
  assign wr_acc    = bus.write_en && write_rdy;
  assign rd_acc    = bus.read_en  && read_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_acc) mem_q[wr_ptr_q] <= bus.write_data;
    end
  end

  assign bus.write_rdy    = write_rdy;
  assign bus.read_rdy     = read_rdy;
  assign bus.read_data    = mem_q[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);

`ifdef FIFO_N_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the same cycle as err_clr must survive the clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.write_en && !write_rdy) overflow_d  = 1'b1;
    if (bus.read_en  && !read_rdy)  underflow_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_n.sv
// Directed bench for fifo_n (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1).
module tb_fifo_n;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef FIFO_N_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  fifo_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the edge, outputs sampled there too
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_en   = 1'b0;
    bus.write_data = '0;
    bus.read_en    = 1'b0;
    bus.err_clr    = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bus.write_en   = 1'b1;
    bus.write_data = d;
    step();
    bus.write_en   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [WIDTH-1:0] exp);
    check(tag, 32'(bus.read_data), 32'(exp));
    bus.read_en = 1'b1;
    step();
    bus.read_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},  32'(bus.count),        32'd0);
    check({tag, "_wrdy"},   32'(bus.write_rdy),    32'd1);
    check({tag, "_rrdy"},   32'(bus.read_rdy),     32'd0);
    check({tag, "_rdata"},  32'(bus.read_data),    32'h00);
    check({tag, "_ae"},     32'(bus.almost_empty), 32'd1);
    check({tag, "_af"},     32'(bus.almost_full),  32'd0);
    check({tag, "_ovf"},    32'(bus.overflow),     32'd0);
    check({tag, "_unf"},    32'(bus.underflow),    32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] fill [4];
    logic [WIDTH-1:0] wdata;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    step();
    check_reset_outputs("idle");

    // fill four entries
    for (int i = 0; i < 4; i++) begin
      push(fill[i]);
      if (i == 0) begin
        check("wr1_rdata", 32'(bus.read_data), 32'h11);
        check("wr1_rrdy",  32'(bus.read_rdy),  32'd1);
        check("wr1_ae",    32'(bus.almost_empty), 32'd1);
      end
      if (i == 1) check("wr2_ae", 32'(bus.almost_empty), 32'd0);
      if (i == 2) begin
        check("wr3_count", 32'(bus.count),       32'd3);
        check("wr3_af",    32'(bus.almost_full), 32'd1);
        check("wr3_wrdy",  32'(bus.write_rdy),   32'd1);
      end
      if (i == 3) begin
        check("wr4_wrdy",  32'(bus.write_rdy), 32'd0);
        check("wr4_count", 32'(bus.count),     32'd4);
      end
    end

    // drain in order
    for (int i = 0; i < 4; i++) pop_check("drain_data", fill[i]);
    check("drain_rrdy",  32'(bus.read_rdy),     32'd0);
    check("drain_count", 32'(bus.count),        32'd0);
    check("drain_ae",    32'(bus.almost_empty), 32'd1);

    // full with both requests: read wins, write rejected
    for (int i = 0; i < 4; i++) push(fill[i]);
    bus.write_en   = 1'b1;
    bus.read_en    = 1'b1;
    bus.write_data = 8'h55;
    check("full_both_head", 32'(bus.read_data), 32'h11);
    step();
    idle_inputs();
    check("full_both_count", 32'(bus.count),     32'd3);
    check("full_both_rdata", 32'(bus.read_data), 32'h22);
    check("full_both_ovf",   32'(bus.overflow),  32'(ERR_EN));
    check("full_both_unf",   32'(bus.underflow), 32'd0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    pop_check("after_full_data", 8'h22);
    pop_check("after_full_data", 8'h33);
    pop_check("after_full_data", 8'h44);
    check("after_full_rrdy", 32'(bus.read_rdy), 32'd0);

    // empty with both requests: write wins, no bypass
    bus.write_en   = 1'b1;
    bus.read_en    = 1'b1;
    bus.write_data = 8'hA5;
    step();
    idle_inputs();
    check("empty_both_count", 32'(bus.count),     32'd1);
    check("empty_both_rdata", 32'(bus.read_data), 32'hA5);
    check("empty_both_unf",   32'(bus.underflow), 32'(ERR_EN));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("unf_clr",       32'(bus.underflow), 32'd0);
    check("unf_clr_count", 32'(bus.count),     32'd1);
    pop_check("empty_both_pop", 8'hA5);
    check("empty_again", 32'(bus.count), 32'd0);

    // wrap-around: count held at 2 with simultaneous read and write
    wdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(wdata);
      push(wdata);
      wdata = wdata + 8'h01;
    end
    for (int i = 0; i < 10; i++) begin
      check("wrap_data", 32'(bus.read_data), 32'(exp_q.pop_front()));
      exp_q.push_back(wdata);
      bus.write_en   = 1'b1;
      bus.read_en    = 1'b1;
      bus.write_data = wdata;
      step();
      wdata = wdata + 8'h01;
      check("wrap_count", 32'(bus.count), 32'd2);
    end
    idle_inputs();
    while (exp_q.size() > 0) pop_check("wrap_tail", exp_q.pop_front());
    check("wrap_empty", 32'(bus.read_rdy), 32'd0);

    // asynchronous reset mid-operation
    push(8'h61);
    push(8'h62);
    push(8'h63);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #1;
    RST_N = 1'b1;
    step();
    push(8'h7E);
    check("post_rst_rdata", 32'(bus.read_data), 32'h7E);
    check("post_rst_count", 32'(bus.count),     32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_n.md
# fifo_n

Parametrised synchronous FIFO: the multi-entry, multi-bit successor to the single-entry 1-bit buffer. It provides first-word-fall-through reads, same-cycle read and write, an occupancy count, and almost-full/almost-empty thresholds. It sits between producer and consumer stages that use the team's `*_en`/`*_rdy` handshake, and optionally reports protocol errors.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of entries; must be a power of two and >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports (CW = $clog2(DEPTH)+1). Reset RST_N, asynchronous, active-low; clock CLK.
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous active-low reset
- write_en  in  1  write request
- write_data  in  WIDTH  data to enqueue
- write_rdy  out  1  FIFO not full
- read_en  in  1  read (dequeue) request
- read_data  out  WIDTH  head entry (first-word-fall-through)
- read_rdy  out  1  FIFO not empty
- count  out  CW  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- err_clr  in  1  clears the sticky error flags
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write is accepted when write_en && write_rdy: storage[wr_ptr] <= write_data, and wr_ptr advances.
- Read is accepted when read_en && read_rdy: rd_ptr advances. read_data = storage[rd_ptr], driven combinationally from registers.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count increments on write only, decrements on read only, and is unchanged on both or neither.
- write_rdy = (count != DEPTH) and read_rdy = (count != 0). Both are decoded from registered count only, with no combinational path from read_en or write_en.
- Full with both requests asserted: the read is accepted and the write is rejected, so count becomes DEPTH-1.
- Empty with both requests asserted: the write is accepted and the read is rejected, so count becomes 1. No bypass.
- A rejected write leaves storage, pointers and count unchanged. A rejected read does the same.
- almost_full and almost_empty are decoded from count.
- Reset values:
  - State: pointers 0, count 0, all storage entries 0.
  - Outputs: read_data 0, write_rdy 1, read_rdy 0, almost_full 0 (AF_LEVEL>=1), almost_empty 1, overflow 0, underflow 0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write latency: a write accepted at edge k makes the data visible on read_data, with read_rdy high, immediately after edge k.
- Read: the next entry appears on read_data immediately after the edge that accepts the read.
- count, write_rdy, read_rdy, almost_full and almost_empty all update only on the rising edge of CLK.
- Full throughput: one write and one read per cycle, sustained, whenever 0 < count < DEPTH.

## Configuration
- Macro: FIFO_N_ERR_FLAGS_EN.
- When defined:
  - overflow sets on the edge after write_en && !write_rdy.
  - underflow sets on the edge after read_en && !read_rdy.
  - Both flags hold until err_clr is sampled high. If a set and err_clr occur in the same cycle, the set wins.
- When undefined: the error logic is not compiled; overflow and underflow are tied to 0 and err_clr is ignored.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
- Reset then idle:
  - Required outputs: write_rdy=1, read_rdy=0, count=0, read_data=0x00, almost_empty=1, almost_full=0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - After the first write: read_data=0x11.
  - After the third write: count=3, almost_full=1.
  - After the fourth write: write_rdy=0.
  - Draining returns 0x11, 0x22, 0x33, 0x44 in order, ending with read_rdy=0.
- Full with write_en=1, read_en=1, write_data=0x55:
  - The read of 0x11 is accepted and the write is rejected; count=3.
  - With FIFO_N_ERR_FLAGS_EN defined, overflow=1 on the next cycle.
- Empty with write_en=1, read_en=1, write_data=0xA5:
  - count=1 and read_data=0xA5.
  - With FIFO_N_ERR_FLAGS_EN defined, underflow=1; err_clr=1 then clears it on the following edge.
- Wrap-around: 10 cycles of simultaneous read and write with count held at 2 and data incrementing from 0x00. Required: output order is preserved across pointer wrap and count stays 2 throughout.
- Reset mid-operation: assert RST_N=0 with count=3. Required: outputs return to their reset values without a clock edge; the next write of 0x7E reads back as 0x7E.
